// File: rtl/sensor_hub.sv
// Multi-channel DHT11 request/response hub with continuous sampling.
// Define SENSOR_HUB_CHECKSUM_EN to reject frames with a bad checksum.
module sensor_hub #(
  parameter int CHANNELS    = 4,
  parameter int CONT_PERIOD = 50_000_000,
  parameter int TIMEOUT     = 5_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [7:0]              request_command,
  input  logic [7:0]              request_address,
  output logic [CHANNELS-1:0]     sensor_start,
  input  logic [CHANNELS-1:0]     sensor_done,
  input  logic [40*CHANNELS-1:0]  sensor_data,
  output logic                    response_valid,
  output logic [7:0]              response_command,
  output logic [7:0]              response_value,
  output logic                    busy
);

  localparam int MAXC =
    CONT_PERIOD > TIMEOUT ? CONT_PERIOD : TIMEOUT;
  localparam int CNTW = $clog2(MAXC + 1);
  localparam int CHW  =
    CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam logic [CNTW-1:0] TO_LAST =
    CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CP_LAST =
    CNTW'(CONT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    ACQUIRE,
    RESPOND,
    CONT_WAIT,
    CONT_ACQ
  } state_t;

  state_t          state;
  logic            en_q;
  logic [7:0]      cmd;
  logic [CHW-1:0]  ch;
  logic [CNTW-1:0] cnt;
  logic [7:0]      pend_cmd;
  logic [7:0]      pend_val;
  logic            pend_idle;

  logic [39:0] frame [CHANNELS];
  logic [39:0] sel;
  logic        capture;
  logic        done_hit;
  logic        timeout;
  logic        addr_bad;
  logic        stop;
  logic        i_acq;
  logic [7:0]  i_cmd, i_val;
  logic [7:0]  s_cmd, s_val;
  logic [7:0]  q_cmd, q_val;
  logic [7:0]  sum;
  logic [CHW-1:0] req_ch;
  logic        unused;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_frame
    assign frame[g] = sensor_data[40*g +: 40];
  end

  assign sel      = frame[ch];
  assign capture  = enable & ~en_q;
  assign done_hit = sensor_done[ch];
  assign timeout  = (cnt == TO_LAST);
  assign req_ch   = request_address[CHW-1:0];
  assign addr_bad = request_address >= 8'(CHANNELS);
  assign busy     = (state != IDLE);
  assign sum      = sel[39:32] + sel[31:24]
                  + sel[23:16] + sel[15:8];
  assign unused   = ^{sum, sel[7:0]};

  // Stop only when mode and channel match the running stream
  assign stop = capture
    && request_address == 8'(ch)
    && ((request_command == 8'h05 && cmd == 8'h03)
     || (request_command == 8'h06 && cmd == 8'h04));

  assign q_cmd = stop ? 8'h0A : 8'hFF;
  assign q_val = stop ? 8'h00 : 8'hFF;

  always_comb begin
    i_acq = 1'b0;
    i_cmd = 8'h00;
    i_val = 8'h00;
    if (addr_bad) begin
      i_cmd = 8'hEF;
      i_val = 8'hEF;
    end else if (request_command == 8'h05
              || request_command == 8'h06) begin
      i_cmd = 8'hAA;
      i_val = 8'hAA;
    end else if (request_command > 8'h06) begin
      i_cmd = 8'h45;
      i_val = 8'h45;
    end else begin
      i_acq = 1'b1;
    end
  end

  always_comb begin
    s_cmd = 8'h07;
    s_val = 8'h07;
    unique case (1'b1)
      cmd == 8'h01 || cmd == 8'h03: begin
        s_cmd = 8'h09;
        s_val = sel[23:16];
      end
      cmd == 8'h02 || cmd == 8'h04: begin
        s_cmd = 8'h08;
        s_val = sel[39:32];
      end
      default: ;
    endcase
`ifdef SENSOR_HUB_CHECKSUM_EN
    if (sum != sel[7:0]) begin
      s_cmd = 8'h1F;
      s_val = 8'h45;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= IDLE;
      en_q             <= 1'b1;
      cmd              <= '0;
      ch               <= '0;
      cnt              <= '0;
      sensor_start     <= '0;
      response_valid   <= 1'b0;
      response_command <= '0;
      response_value   <= '0;
      pend_cmd         <= '0;
      pend_val         <= '0;
      pend_idle        <= 1'b0;
    end else begin
      en_q           <= enable;
      sensor_start   <= '0;
      response_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (capture && i_acq) begin
            sensor_start[req_ch] <= 1'b1;
            ch    <= req_ch;
            cmd   <= request_command;
            cnt   <= '0;
            state <= ACQUIRE;
          end else if (capture) begin
            response_valid   <= 1'b1;
            response_command <= i_cmd;
            response_value   <= i_val;
          end
        end
        ACQUIRE: begin
          if (done_hit) begin
            response_valid   <= 1'b1;
            response_command <= s_cmd;
            response_value   <= s_val;
            cnt   <= '0;
            state <= (cmd == 8'h03 || cmd == 8'h04)
                   ? CONT_WAIT : IDLE;
          end else if (timeout) begin
            response_valid   <= 1'b1;
            response_command <= 8'h1F;
            response_value   <= 8'h00;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CONT_WAIT: begin
          if (capture) begin
            response_valid   <= 1'b1;
            response_command <= q_cmd;
            response_value   <= q_val;
          end
          if (stop) begin
            state <= IDLE;
          end else if (cnt == CP_LAST) begin
            sensor_start[ch] <= 1'b1;
            cnt   <= '0;
            state <= CONT_ACQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CONT_ACQ: begin
          if (done_hit || timeout) begin
            response_valid   <= 1'b1;
            response_command <= done_hit ? s_cmd : 8'h1F;
            response_value   <= done_hit ? s_val : 8'h00;
            cnt   <= '0;
            state <= done_hit ? CONT_WAIT : IDLE;
            // Colliding request is answered next cycle
            if (capture) begin
              pend_cmd  <= q_cmd;
              pend_val  <= q_val;
              pend_idle <= stop || !done_hit;
              state     <= RESPOND;
            end
          end else if (capture) begin
            response_valid   <= 1'b1;
            response_command <= q_cmd;
            response_value   <= q_val;
            if (stop) state <= IDLE;
            else cnt <= cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESPOND: begin
          response_valid   <= 1'b1;
          response_command <= pend_cmd;
          response_value   <= pend_val;
          cnt   <= '0;
          state <= pend_idle ? IDLE : CONT_WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_hub.sv
// Scoreboard bench for sensor_hub: CHANNELS=4,
// CONT_PERIOD=16, TIMEOUT=100.
module tb_sensor_hub;

  localparam int CH = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b1;
  logic [7:0]      request_command = 8'h01;
  logic [7:0]      request_address = 8'h00;
  logic [CH-1:0]   sensor_start;
  logic [CH-1:0]   sensor_done = '0;
  logic [40*CH-1:0] sensor_data;
  logic            response_valid;
  logic [7:0]      response_command;
  logic [7:0]      response_value;
  logic            busy;

  logic [39:0] frame [CH];

  for (genvar g = 0; g < CH; g++) begin : g_fr
    assign sensor_data[40*g +: 40] = frame[g];
  end

  sensor_hub #(
    .CHANNELS   (CH),
    .CONT_PERIOD(16),
    .TIMEOUT    (100)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .request_command (request_command),
    .request_address (request_address),
    .sensor_start    (sensor_start),
    .sensor_done     (sensor_done),
    .sensor_data     (sensor_data),
    .response_valid  (response_valid),
    .response_command(response_command),
    .response_value  (response_value),
    .busy            (busy)
  );

  typedef struct {
    string      tag;
    logic [7:0] c;
    logic [7:0] v;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] mkframe(
      input logic [7:0] h, input logic [7:0] t);
    logic [7:0] s;
    s = h + t;
    return {h, 8'h00, t, 8'h00, s};
  endfunction

  task automatic push_exp(input string tag,
                          input logic [7:0] c,
                          input logic [7:0] v,
                          input int due);
    exp_t e;
    e.tag = tag;
    e.c   = c;
    e.v   = v;
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic req(input logic [7:0] c,
                     input logic [7:0] a);
    request_command = c;
    request_address = a;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic wait_start(output int at,
                            output logic [CH-1:0] v);
    at = -1;
    v  = '0;
    for (int i = 0; i < 64; i++) begin
      if (sensor_start != '0) begin
        at = cyc;
        v  = sensor_start;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic done_pulse(input int c);
    sensor_done[c] = 1'b1;
    @(negedge clock);
    sensor_done = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, 32'(sensor_start), 0);
    chk({tag, "_valid"}, 32'(response_valid), 0);
    chk({tag, "_rcmd"}, 32'(response_command), 0);
    chk({tag, "_rval"}, 32'(response_value), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  always @(negedge clock) begin
    if (response_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(sb.size()), 1);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_cmd"},
            32'(response_command), 32'(mon_e.c));
        chk({mon_e.tag, "_val"},
            32'(response_value), 32'(mon_e.v));
        chk({mon_e.tag, "_cyc"}, cyc, mon_e.due);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2, r;
    logic [CH-1:0] v;

    for (int i = 0; i < CH; i++)
      frame[i] = mkframe(8'h20, 8'h10);
    frame[2] = 40'h28_00_19_00_41;

    // reset with enable held high
    repeat (3) @(negedge clock);
    chk_zero("rst");
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_en_held_busy", 32'(busy), 0);
    enable = 1'b0;
    @(negedge clock);

    // single temperature read on channel 2
    req(8'h01, 8'h02);
    wait_start(s, v);
    chk("t38_start_vec", 32'(v), 32'h4);
    chk("t38_start_lat", s, cyc);
    @(negedge clock);
    chk("t38_start_once", 32'(sensor_start), 0);
    sensor_done[1] = 1'b1;
    @(negedge clock);
    sensor_done = '0;
    req(8'h00, 8'h00);
    wait_until(s + 10);
    push_exp("t38", 8'h09, 8'h19, cyc + 1);
    done_pulse(2);
    repeat (3) @(negedge clock);
    chk("t38_idle_busy", 32'(busy), 0);

    // bad checksum frame
    frame[2] = 40'h28_00_19_00_42;
    req(8'h01, 8'h02);
    wait_start(s, v);
    wait_until(s + 4);
`ifdef SENSOR_HUB_CHECKSUM_EN
    push_exp("ck_bad", 8'h1F, 8'h45, cyc + 1);
`else
    push_exp("ck_bad", 8'h09, 8'h19, cyc + 1);
`endif
    done_pulse(2);
    frame[2] = 40'h28_00_19_00_41;
    repeat (3) @(negedge clock);

    // immediate responses
    push_exp("bad_addr", 8'hEF, 8'hEF, cyc + 1);
    req(8'h00, 8'h05);
    chk("bad_addr_start", 32'(sensor_start), 0);
    @(negedge clock);
    push_exp("idle_stop", 8'hAA, 8'hAA, cyc + 1);
    req(8'h05, 8'h01);
    @(negedge clock);
    push_exp("bad_cmd", 8'h45, 8'h45, cyc + 1);
    req(8'h33, 8'h00);
    chk("bad_cmd_busy", 32'(busy), 0);
    @(negedge clock);

    // status read on channel 3
    req(8'h00, 8'h03);
    wait_start(s, v);
    chk("st_start_vec", 32'(v), 32'h8);
    wait_until(s + 5);
    push_exp("status", 8'h07, 8'h07, cyc + 1);
    done_pulse(3);
    repeat (3) @(negedge clock);

    // timeout
    req(8'h00, 8'h01);
    wait_start(s, v);
    chk("to_start_vec", 32'(v), 32'h2);
    push_exp("timeout", 8'h1F, 8'h00, s + 100);
    wait_until(s + 102);
    chk("to_idle_busy", 32'(busy), 0);
    done_pulse(1);
    repeat (3) @(negedge clock);

    // continuous humidity on channel 0
    frame[0] = mkframe(8'h30, 8'h15);
    req(8'h04, 8'h00);
    wait_start(s, v);
    chk("cont_start_vec", 32'(v), 32'h1);
    wait_until(s + 3);
    push_exp("cont0", 8'h08, 8'h30, cyc + 1);
    done_pulse(0);
    r = cyc;
    for (int k = 1; k <= 3; k++) begin
      frame[0] = mkframe(8'h30 + 8'(k), 8'h15);
      wait_start(s, v);
      chk("cont_period", s, r + 16);
      chk("cont_vec", 32'(v), 32'h1);
      wait_until(s + 3);
      push_exp("cont_k", 8'h08, 8'h30 + 8'(k),
               cyc + 1);
      done_pulse(0);
      r = cyc;
    end
    @(negedge clock);
    chk("cont_busy", 32'(busy), 1);
    push_exp("cont_other", 8'hFF, 8'hFF, cyc + 1);
    req(8'h02, 8'h00);
    @(negedge clock);
    push_exp("cont_wrong", 8'hFF, 8'hFF, cyc + 1);
    req(8'h05, 8'h00);
    @(negedge clock);
    push_exp("cont_stop", 8'h0A, 8'h00, cyc + 1);
    req(8'h06, 8'h00);
    chk("cont_stop_busy", 32'(busy), 0);
    repeat (3) @(negedge clock);

    // collision of done and request
    frame[1] = mkframe(8'h40, 8'h21);
    req(8'h03, 8'h01);
    wait_start(s, v);
    wait_until(s + 2);
    push_exp("col0", 8'h09, 8'h21, cyc + 1);
    done_pulse(1);
    r = cyc;
    frame[1] = mkframe(8'h41, 8'h22);
    wait_start(s2, v);
    chk("col_period", s2, r + 16);
    wait_until(s2 + 2);
    request_command = 8'h01;
    request_address = 8'h02;
    enable = 1'b1;
    sensor_done[1] = 1'b1;
    push_exp("col_sensor", 8'h09, 8'h22, cyc + 1);
    push_exp("col_req", 8'hFF, 8'hFF, cyc + 2);
    @(negedge clock);
    enable = 1'b0;
    sensor_done = '0;
    repeat (3) @(negedge clock);
    chk("col_busy", 32'(busy), 1);
    push_exp("col_stop", 8'h0A, 8'h00, cyc + 1);
    req(8'h05, 8'h01);
    chk("col_stop_busy", 32'(busy), 0);
    repeat (3) @(negedge clock);

    // reset in the middle of an acquisition
    req(8'h02, 8'h03);
    wait_start(s, v);
    chk("mid_start_vec", 32'(v), 32'h8);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk_zero("mid_rst");
    reset = 1'b1;
    repeat (2) @(negedge clock);
    done_pulse(3);
    repeat (4) @(negedge clock);
    chk("mid_after_valid", 32'(response_valid), 0);
    chk("mid_after_busy", 32'(busy), 0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sensor_hub.md
SENSOR_HUB -- requirements
Module: sensor_hub

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of DHT11-type sensor channels (1..16).
REQ-002 SHALL have parameter CONT_PERIOD, default 50_000_000: clock cycles between continuous-mode samples.
REQ-003 SHALL have parameter TIMEOUT, default 5_000_000: cycles allowed from sensor_start to sensor_done.
REQ-004 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port enable  in  1  request strobe; a request is captured on a 0->1 transition.
REQ-007 SHALL have port request_command  in  8  command code.
REQ-008 SHALL have port request_address  in  8  target channel index.
REQ-009 SHALL have port sensor_start  out  CHANNELS  one-cycle per-channel measurement start pulse.
REQ-010 SHALL have port sensor_done  in  CHANNELS  per-channel frame-ready pulse.
REQ-011 SHALL have port sensor_data  in  40*CHANNELS  channel i frame at [40i+39:40i]: hum_int, hum_frac, temp_int, temp_frac, checksum (MSB first).
REQ-012 SHALL have port response_valid  out  1  one-cycle pulse; response_command/response_value valid that cycle and held until the next pulse.
REQ-013 SHALL have port response_command  out  8  response code.
REQ-014 SHALL have port response_value  out  8  response payload.
REQ-015 SHALL have port busy  out  1  high in any state other than IDLE, or while continuous mode is active.

Function
REQ-016 SHALL implement states IDLE, ACQUIRE, RESPOND, CONT_WAIT, CONT_ACQ.
REQ-017 SHALL, in IDLE, treat request_address >= CHANNELS as an error: respond 0xEF/0xEF without pulsing sensor_start.
REQ-018 SHALL, in IDLE, handle commands 0x05 and 0x06 by responding 0xAA/0xAA (continuous mode not active).
REQ-019 SHALL, in IDLE, handle any command other than 0x00-0x06 by responding 0x45/0x45.
REQ-020 SHALL, in IDLE, for commands 0x00-0x04, pulse sensor_start[addr] the cycle after capture and enter ACQUIRE.
REQ-021 SHALL ignore sensor_done bits of other channels while in ACQUIRE.
REQ-022 SHALL respond as follows once sensor_done[addr] is seen: 0x00 -> 0x07/0x07; 0x01 -> 0x09/temp_int; 0x02 -> 0x08/hum_int; 0x03 -> 0x09/temp_int then CONT_WAIT; 0x04 -> 0x08/hum_int then CONT_WAIT.
REQ-023 SHALL pulse response_valid exactly 1 cycle after the cycle in which sensor_done[addr] is sampled high.
REQ-024 SHALL pulse response_valid 1 cycle after capture for immediate responses (REQ-017 to REQ-019).
REQ-025 SHALL, if TIMEOUT cycles elapse in ACQUIRE or CONT_ACQ without sensor_done[addr], respond 0x1F/0x00, then return to IDLE and clear continuous mode.
REQ-026 SHALL count CONT_PERIOD cycles in CONT_WAIT, then pulse sensor_start[addr] and enter CONT_ACQ; CONT_ACQ responds as in REQ-022 and returns to CONT_WAIT.
REQ-027 SHALL latch the continuous channel and its mode (temp/hum) at entry and keep them while continuous mode lasts.
REQ-028 SHALL, in continuous mode, handle a captured 0x05 (temp) or 0x06 (hum) matching the active mode and channel by responding 0x0A/0x00 and returning to IDLE.
REQ-029 SHALL, in continuous mode, answer any other captured request with 0xFF/0xFF; continuous mode continues.
REQ-030 SHALL, if a capture and a sensor_done response fall in the same cycle, emit the sensor response first and the request response on the next cycle (no loss).
REQ-031 SHALL ignore enable edges in ACQUIRE (single request outstanding); no response is generated for them.
REQ-032 SHALL size counters to hold max(CONT_PERIOD, TIMEOUT) without wrap.

Reset
REQ-033 SHALL, with reset low at a clock edge, set state to IDLE, clear continuous mode, and zero sensor_start, response_valid, response_command, response_value, busy and all counters.
REQ-034 SHALL discard any in-flight acquisition when reset asserts mid-operation; a later sensor_done produces no response.
REQ-035 SHALL initialise the enable edge detector to 1 so that enable held high through reset is not captured.

Configuration
REQ-036 SHALL, with SENSOR_HUB_CHECKSUM_EN defined, check every frame (checksum == sum of the four data bytes, mod 256); on mismatch the response is 0x1F/0x45 and continuous mode continues.
REQ-037 SHALL, without SENSOR_HUB_CHECKSUM_EN, ignore the checksum byte entirely.

Verification
REQ-038 SHALL be tested with CHANNELS=4, cmd 0x01, addr 2, frame 0x28_00_19_00_41 on channel 2, done 10 cycles after start -> sensor_start=0b0100 once; response_valid 1 cycle after done with 0x09/0x19.
REQ-039 SHALL be tested with addr 5 and cmd 0x00 -> 0xEF/0xEF 1 cycle after capture and no sensor_start.
REQ-040 SHALL be tested with CONT_PERIOD=16, cmd 0x04 addr 0, then 3 samples, then cmd 0x02 -> 0x08 responses spaced 16+latency cycles, 0xFF/0xFF for cmd 0x02; then cmd 0x06 -> 0x0A/0x00 and busy=0.
REQ-041 SHALL be tested with TIMEOUT=100, cmd 0x00, and no done -> 0x1F/0x00 at cycle 100 and state IDLE.
REQ-042 SHALL be tested with SENSOR_HUB_CHECKSUM_EN and checksum 0x42 on REQ-038's frame -> 0x1F/0x45; without the macro -> 0x09/0x19.
REQ-043 SHALL be tested with reset asserted mid-ACQUIRE, then done pulsed -> no response_valid and all outputs zero.
